// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the CPU memory/bus controller and its I/O register block.
package mem_bus_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ACCESS,
      ST_WAIT,
      ST_RESP
   } state_t;

   // Byte offsets of the I/O registers relative to IO_BASE
   localparam logic [3:0] IO_OFF_LED = 4'h0;
   localparam logic [3:0] IO_OFF_SW  = 4'h4;
   localparam logic [3:0] IO_OFF_CNT = 4'h8;

   typedef enum logic [2:0] {
      ERR_NONE,
      ERR_BOTH,
      ERR_MISALIGN,
      ERR_UNMAPPED,
      ERR_IO_ACCESS
   } err_cause_t;

endpackage

// File: rtl/mem_bus_if.sv
// CPU-side request/response bus between the multi-cycle CPU and the memory/bus controller.
interface mem_bus_if;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        read;
   logic        write;
   logic [31:0] rdata;
   logic        ready;
   logic        err;

   // Handshake: the requester raises read or write (level) with addr/wdata stable and holds
   // them until ready; ready is a one-cycle completion pulse qualifying rdata and err.
   modport master (output addr, wdata, read, write, input rdata, ready, err);
   modport slave  (input addr, wdata, read, write, output rdata, ready, err);
endinterface

// File: rtl/mem_io_regs.sv
// Memory-mapped I/O block: LED register, synchronised switches and a free-running cycle counter.
module mem_io_regs
   import mem_bus_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic        wr,
   input  logic [3:0]  off,
   input  logic [15:0] wdata,
   input  logic [15:0] sw_in,
   output logic [31:0] rdata,
   output logic        illegal,
   output logic [15:0] led_out
);

   logic [15:0] sw_s1;
   logic [15:0] sw_s2;
   logic [31:0] cnt_q;
   logic        wr_stb;

   always_comb begin
      rdata   = '0;
      illegal = 1'b0;
      case (off)
         IO_OFF_LED: rdata = {16'h0000, led_out};
         IO_OFF_SW: begin
            rdata   = {16'h0000, sw_s2};
            illegal = wr;
         end
         IO_OFF_CNT: rdata = cnt_q;
         default:    illegal = 1'b1;
      endcase
   end

   assign wr_stb = req & wr & ~illegal;

   // A counter write wins over the increment on that edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sw_s1   <= '0;
         sw_s2   <= '0;
         led_out <= '0;
         cnt_q   <= '0;
      end else begin
         sw_s1 <= sw_in;
         sw_s2 <= sw_s1;
         if (wr_stb && off == IO_OFF_LED) led_out <= wdata;
         if (wr_stb && off == IO_OFF_CNT) cnt_q <= '0;
         else                             cnt_q <= cnt_q + 32'd1;
      end
   end

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory/bus controller: decodes CPU requests to block RAM (with wait states) or I/O registers,
// completing every request, including malformed ones, with a one-cycle ready pulse.
module mem_bus_ctrl
   import mem_bus_pkg::*;
#(
   parameter  int          RAM_WORDS   = 1024,
   parameter  int          RAM_LATENCY = 1,
   parameter  logic [31:0] IO_BASE     = 32'hFFFF_0000,
   localparam int          AW          = $clog2(RAM_WORDS)
) (
   input  logic            clk,
   input  logic            rst,
   mem_bus_if.slave        cpu,
   output logic            ram_en,
   output logic            ram_we,
   output logic [AW-1:0]   ram_addr,
   output logic [31:0]     ram_wdata,
   input  logic [31:0]     ram_rdata,
   input  logic [15:0]     sw_in,
   output logic [15:0]     led_out,
   output state_t          dbg_state,
   output err_cause_t      dbg_err
);

   localparam logic [32:0] RAM_BYTES = 33'(RAM_WORDS) * 33'd4;

   state_t      state_q, state_d;
   err_cause_t  cause, cause_q;
   logic [AW-1:0] addr_q;
   logic [31:0] wdata_q;
   logic        wr_q;
   logic [2:0]  wcnt_q;
   logic [31:0] rdata_q;
   logic        err_q;
   logic        req, ram_hit, io_hit, ram_go, io_req, io_illegal;
   logic [31:0] io_rdata;

   assign req     = cpu.read | cpu.write;
   assign ram_hit = {1'b0, cpu.addr} < RAM_BYTES;
   assign io_hit  = cpu.addr[31:4] == IO_BASE[31:4];

   // Priority: conflicting strobes, then alignment, then address map
   always_comb begin
      cause = ERR_NONE;
      if (cpu.read && cpu.write)       cause = ERR_BOTH;
      else if (cpu.addr[1:0] != 2'b00) cause = ERR_MISALIGN;
      else if (ram_hit)                cause = ERR_NONE;
      else if (!io_hit)                cause = ERR_UNMAPPED;
      else if (io_illegal)             cause = ERR_IO_ACCESS;
   end

   assign ram_go = (cause == ERR_NONE) && ram_hit;
   assign io_req = (state_q == ST_IDLE) && req && (cause == ERR_NONE) && !ram_hit;

   mem_io_regs u_io (
      .clk     (clk),
      .rst     (rst),
      .req     (io_req),
      .wr      (cpu.write),
      .off     (cpu.addr[3:0]),
      .wdata   (cpu.wdata[15:0]),
      .sw_in   (sw_in),
      .rdata   (io_rdata),
      .illegal (io_illegal),
      .led_out (led_out)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (req) state_d = ram_go ? ST_ACCESS : ST_RESP;
         ST_ACCESS: state_d = ST_WAIT;
         ST_WAIT:   if (wcnt_q == 3'd1) state_d = ST_RESP;
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_q  <= '0;
         wdata_q <= '0;
         wr_q    <= 1'b0;
         wcnt_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cause_q <= ERR_NONE;
      end else begin
         case (state_q)
            ST_IDLE: if (req) begin
               addr_q  <= cpu.addr[AW+1:2];
               wdata_q <= cpu.wdata;
               wr_q    <= cpu.write;
               cause_q <= cause;
               // I/O and error responses are ready right away; RAM results land in WAIT
               if (!ram_go) begin
                  err_q   <= (cause != ERR_NONE);
                  rdata_q <= (cause == ERR_NONE && cpu.read) ? io_rdata : '0;
               end
            end
            ST_ACCESS: wcnt_q <= 3'(RAM_LATENCY);
            ST_WAIT: begin
               wcnt_q <= wcnt_q - 3'd1;
               if (wcnt_q == 3'd1) begin
                  rdata_q <= wr_q ? '0 : ram_rdata;
                  err_q   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign ram_en    = (state_q == ST_ACCESS);
   assign ram_we    = ram_en & wr_q;
   assign ram_addr  = addr_q;
   assign ram_wdata = wdata_q;

   assign cpu.ready = (state_q == ST_RESP);
   assign cpu.rdata = rdata_q;
   assign cpu.err   = err_q;
   assign dbg_state = state_q;
   assign dbg_err   = cause_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: CPU transactions against a behavioural one-cycle block RAM,
// responses checked by a scoreboard monitor, latency and RAM strobes checked by the driver.
module tb_mem_bus_ctrl;
   import mem_bus_pkg::*;

   localparam int          RAM_WORDS = 1024;
   localparam int          AW        = 10;
   localparam logic [31:0] IO        = 32'hFFFF_0000;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          ram_en, ram_we;
   logic [AW-1:0] ram_addr;
   logic [31:0]   ram_wdata;
   logic [31:0]   ram_rdata;
   logic [15:0]   sw_in;
   logic [15:0]   led_out;
   state_t        dbg_state;
   err_cause_t    dbg_err;

   mem_bus_if bus ();

   mem_bus_ctrl #(.RAM_WORDS(RAM_WORDS), .RAM_LATENCY(1), .IO_BASE(IO)) dut (
      .clk       (clk),
      .rst       (rst),
      .cpu       (bus),
      .ram_en    (ram_en),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata),
      .sw_in     (sw_in),
      .led_out   (led_out),
      .dbg_state (dbg_state),
      .dbg_err   (dbg_err)
   );

   // clock
   always #5 clk = ~clk;

   // synchronous RAM, one cycle read latency
   logic [31:0] mem [RAM_WORDS];
   always @(posedge clk) begin
      if (ram_en) begin
         if (ram_we) mem[ram_addr] <= ram_wdata;
         ram_rdata <= mem[ram_addr];
      end
   end

   // strobe counters
   int en_cnt = 0;
   int we_cnt = 0;
   always @(negedge clk) begin
      if (ram_en) en_cnt++;
      if (ram_we) we_cnt++;
   end

   // scoreboard: {range_flag, err, rdata}; range_flag accepts any rdata <= 2
   logic [33:0] exp_q[$];
   logic [33:0] e;
   logic        ok;
   int          total = 0;
   int          bad   = 0;

   always @(negedge clk) begin
      if (!rst && bus.ready) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_ready: rdata=%h err=%b with nothing pending",
                     bus.rdata, bus.err);
         end else begin
            e = exp_q.pop_front();
            if (e[33]) ok = (bus.rdata <= 32'd2) && (bus.err == e[32]);
            else       ok = (bus.rdata == e[31:0]) && (bus.err == e[32]);
            if (!ok) begin
               bad++;
               $display("FAIL resp: got rdata=%h err=%b want rdata=%h err=%b (range=%b)",
                        bus.rdata, bus.err, e[31:0], e[32], e[33]);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // driver: one transaction, started in an IDLE cycle
   task automatic do_req(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_d, input logic exp_e,
                         input int exp_lat, input int exp_en, input int exp_we,
                         input logic rng);
      int lat, en0, we0;
      @(negedge clk);
      while (bus.ready) @(negedge clk);
      en0 = en_cnt;
      we0 = we_cnt;
      exp_q.push_back({rng, exp_e, exp_d});
      bus.addr  = a;
      bus.wdata = wd;
      bus.read  = rd;
      bus.write = wr;
      lat = 0;
      do begin
         @(posedge clk);
         #1;
         lat++;
      end while (!bus.ready && lat < 20);
      bus.read  = 1'b0;
      bus.write = 1'b0;
      check("latency", 32'(lat), 32'(exp_lat));
      check("ram_en_cycles", 32'(en_cnt - en0), 32'(exp_en));
      check("ram_we_cycles", 32'(we_cnt - we0), 32'(exp_we));
   endtask

   initial begin
      bus.addr  = '0;
      bus.wdata = '0;
      bus.read  = 1'b0;
      bus.write = 1'b0;
      sw_in     = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", 32'(bus.ready), 32'd0);
      check("rst_rdata", bus.rdata, 32'd0);
      check("rst_err", 32'(bus.err), 32'd0);
      check("rst_led", 32'(led_out), 32'd0);
      check("rst_ram_en", 32'(ram_en), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
      @(negedge clk);
      rst = 1'b0;

      // RAM write/read, including the last RAM word
      do_req(0, 1, 32'h10, 32'hDEAD_BEEF, 32'h0, 0, 3, 1, 1, 0);
      do_req(1, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 3, 1, 0, 0);
      do_req(0, 1, 32'hFFC, 32'h1234_5678, 32'h0, 0, 3, 1, 1, 0);
      do_req(1, 0, 32'hFFC, 32'h0, 32'h1234_5678, 0, 3, 1, 0, 0);

      // LED register
      do_req(0, 1, IO, 32'h0001_A5A5, 32'h0, 0, 1, 0, 0, 0);
      check("led_after_write", 32'(led_out), 32'h0000_A5A5);
      do_req(1, 0, IO, 32'h0, 32'h0000_A5A5, 0, 1, 0, 0, 0);

      // switches: synchronised read, then illegal write
      sw_in = 16'h1234;
      repeat (3) @(posedge clk);
      do_req(1, 0, IO + 32'd4, 32'h0, 32'h0000_1234, 0, 1, 0, 0, 0);
      do_req(0, 1, IO + 32'd4, 32'hFFFF_FFFF, 32'h0, 1, 1, 0, 0, 0);
      check("led_after_sw_write", 32'(led_out), 32'h0000_A5A5);

      // counter: clear, then two reads two cycles apart
      do_req(0, 1, IO + 32'd8, 32'hFFFF_FFFF, 32'h0, 0, 1, 0, 0, 0);
      do_req(1, 0, IO + 32'd8, 32'h0, 32'd1, 0, 1, 0, 0, 0);
      do_req(1, 0, IO + 32'd8, 32'h0, 32'd3, 0, 1, 0, 0, 0);

      // counter wrap from all-ones
      @(negedge clk);
      force dut.u_io.cnt_q = 32'hFFFF_FFFF;
      @(negedge clk);
      release dut.u_io.cnt_q;
      do_req(1, 0, IO + 32'd8, 32'h0, 32'h0, 0, 1, 0, 0, 1);

      // error paths: misaligned, unmapped, RAM end, hole in I/O window, both strobes
      do_req(1, 0, 32'h3, 32'h0, 32'h0, 1, 1, 0, 0, 0);
      do_req(1, 0, 32'h8000_0000, 32'h0, 32'h0, 1, 1, 0, 0, 0);
      do_req(1, 0, 32'h0000_1000, 32'h0, 32'h0, 1, 1, 0, 0, 0);
      do_req(1, 0, IO + 32'd12, 32'h0, 32'h0, 1, 1, 0, 0, 0);
      do_req(1, 1, 32'h10, 32'h5555_5555, 32'h0, 1, 1, 0, 0, 0);
      check("led_after_errors", 32'(led_out), 32'h0000_A5A5);

      // reset while waiting on RAM
      @(negedge clk);
      while (bus.ready) @(negedge clk);
      exp_q.push_back({2'b00, 32'h0000_1234});
      bus.addr = IO + 32'd4;
      bus.read = 1'b1;
      @(posedge clk);
      #1;
      bus.addr = 32'h10;
      @(negedge clk);
      while (bus.ready) @(negedge clk);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      check("in_wait", 32'(dbg_state), 32'(ST_WAIT));
      rst = 1'b1;
      #1;
      check("abort_ready", 32'(bus.ready), 32'd0);
      check("abort_rdata", bus.rdata, 32'd0);
      check("abort_err", 32'(bus.err), 32'd0);
      check("abort_led", 32'(led_out), 32'd0);
      check("abort_ram_en", 32'(ram_en), 32'd0);
      check("abort_state", 32'(dbg_state), 32'(ST_IDLE));
      @(negedge clk);
      bus.read = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("no_ready_after_abort", 32'(bus.ready), 32'd0);
      do_req(1, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, 3, 1, 0, 0);

      @(negedge clk);
      #1;
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end

endmodule

// File: doc/mem_bus_ctrl.md
# mem_bus_ctrl

Memory/bus controller sitting directly downstream of the multi-cycle CPU's memory port. Accepts the CPU's word-wide read/write requests (address, write data, read/write strobes), decodes them to an on-chip synchronous block RAM or a small memory-mapped I/O region, inserts RAM wait states, and returns read data with a one-cycle `cpu_ready` pulse. Misaligned, unmapped or ill-formed requests are completed with an error flag, never hung.

## Interface
- `RAM_WORDS`, 1024: RAM depth in 32-bit words; RAM occupies byte addresses 0 .. RAM_WORDS*4-1.
- `RAM_LATENCY`, 1: cycles from `ram_en` to valid `ram_rdata`; legal range 1..7.
- `IO_BASE`, 32'hFFFF_0000: base of I/O region.
- `clk`  in  1  clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `cpu_addr`  in  32  byte address.
- `cpu_wdata`  in  32  write data.
- `cpu_read`  in  1  read request, level.
- `cpu_write`  in  1  write request, level.
- `cpu_rdata`  out  32  read data, registered, valid while `cpu_ready`=1.
- `cpu_ready`  out  1  one-cycle completion pulse.
- `cpu_err`  out  1  error flag, registered, valid while `cpu_ready`=1.
- `ram_en`  out  1  RAM enable.
- `ram_we`  out  1  RAM write enable.
- `ram_addr`  out  log2(RAM_WORDS)  word address.
- `ram_wdata`  out  32  RAM write data.
- `ram_rdata`  in  32  RAM read data.
- `sw_in`  in  16  asynchronous switch inputs.
- `led_out`  out  16  LED register.

## Operation
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE: on an edge with `cpu_read` or `cpu_write` high, latch addr/wdata/op and decode:
  - Both strobes high: error; go to RESP; no side effects.
  - `addr[1:0]`≠0: misaligned error, go to RESP.
  - addr < RAM_WORDS*4: go to ACCESS.
  - IO_BASE+0: LED reg, R/W; write updates `led_out[15:0]` from `wdata[15:0]` at this edge; read returns zero-extended value.
  - IO_BASE+4: switches, RO, through a 2-flop synchroniser; read returns zero-extended value; write is an error.
  - IO_BASE+8: 32-bit free-running cycle counter, +1 every cycle, wraps 0xFFFFFFFF→0; read returns value at sampling edge; write clears to 0 (write beats increment).
  - Anything else: unmapped error.
  - I/O and error paths load `cpu_rdata` (0 on error) and `cpu_err` at the same edge, then go to RESP.
- ACCESS: `ram_en`=1, `ram_we`=op is write, `ram_addr`=addr[..:2], `ram_wdata`=latched wdata (all combinational from state and latches, exactly one cycle). Load wait counter with RAM_LATENCY, then go to WAIT.
- WAIT: decrement counter each edge; at the edge where counter=1, capture `ram_rdata` into `cpu_rdata` (reads only; writes return 0), clear `cpu_err`, go to RESP.
- RESP: `cpu_ready`=1 for exactly this cycle; requests are ignored; go to IDLE.
- Requester holds strobes/addr/wdata until `cpu_ready`. Strobes still high in the IDLE cycle after RESP start a new transaction (back-to-back is legal).

## Timing
- Request sampled at edge E0.
- I/O or error: `cpu_ready` high in cycle E0→E1 (latency 1).
- RAM: ACCESS E0→E1; WAIT for RAM_LATENCY cycles; `cpu_ready` high in cycle after edge E1+RAM_LATENCY (latency 2+RAM_LATENCY; 3 at default).
- Reset values: state IDLE, `cpu_ready` 0, `cpu_rdata` 0, `cpu_err` 0, `led_out` 0, `ram_en`/`ram_we` 0, counter 0, synchroniser flops 0.
- Reset mid-transaction: abort immediately, no `cpu_ready` issued. A RAM write already strobed in ACCESS is not undone.
- Between transactions, `cpu_rdata` and `cpu_err` hold their last values.

## Structure
- Package `mem_bus_pkg`: state enum; I/O offset constants (LED=0, SW=4, CNT=8); error-cause encoding.
- Sub-module `mem_io_regs`: LED register, switch synchroniser, cycle counter; read mux by offset; write strobe; illegal-access flag.
- The top module holds the FSM, decode, wait counter and RAM port.

## Test plan
- RAM write 0xDEADBEEF to 0x10, then read 0x10 → `ram_en` high one cycle each; `cpu_ready` 3 cycles after each request; read data 0xDEADBEEF; `cpu_err`=0.
- Write 0x0001A5A5 to IO_BASE, then read IO_BASE → `led_out`=0xA5A5 after the write edge; read returns 0x0000A5A5; latency 1.
- Drive `sw_in`=0x1234, wait 2 cycles, read IO_BASE+4 → 0x00001234. Write to IO_BASE+4 → `cpu_err`=1, `led_out` unchanged.
- Read counter, write IO_BASE+8, read again → second read returns a small value (1–2); counter forced near 0xFFFFFFFF wraps to 0.
- Reads at 0x3 (misaligned) and 0x8000_0000 (unmapped), and `cpu_read`=`cpu_write`=1 → `cpu_err`=1, `cpu_rdata`=0, no `ram_en`.
- Assert `rst` during WAIT → no `cpu_ready`; all outputs at reset values. Next request completes normally.
